// File: rtl/pc_flow_ctrl_if.sv
// Handshake bundle between the execute stage and the PC / control-flow stage.
// The master drives the instruction controls and ALU results; the slave returns the PC, flags and status.
interface pc_flow_ctrl_if;
    logic [15:0] dst;
    logic        zr;
    logic        ov;
    logic        we_z;
    logic        we_v;
    logic        we_n;
    logic        br;
    logic [2:0]  cond;
    logic [8:0]  br_off;
    logic        jal;
    logic [11:0] jmp_off;
    logic        jr;
    logic [15:0] jr_tgt;
    logic        hlt;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        taken;
    logic        halted;
    logic [2:0]  flags;

    modport master (
        output dst, zr, ov, we_z, we_v, we_n, br, cond, br_off,
               jal, jmp_off, jr, jr_tgt, hlt, stall,
        input  pc, pc_plus1, taken, halted, flags
    );

    modport slave (
        input  dst, zr, ov, we_z, we_v, we_n, br, cond, br_off,
               jal, jmp_off, jr, jr_tgt, hlt, stall,
        output pc, pc_plus1, taken, halted, flags
    );
endinterface

// File: rtl/pc_flow_ctrl.sv
// PC register, condition flags (Z, V, N) and RUN/HALT sequencing for the single-cycle datapath.
// Define PC_FLOW_OVFL_EN to implement the V flag and the OVFL (110) branch condition.
module pc_flow_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic           clk,
    input  logic           rst,
    pc_flow_ctrl_if.slave  bus
);
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] pc_inc;
    logic        z_reg, z_next;
    logic        n_reg, n_next;
    logic        v_flag;
    logic        cond_true;
    logic        run;
    logic        advance;

    assign run     = (state_reg == RUN);
    assign advance = run && !bus.stall;
    assign pc_inc  = pc_reg + 16'd1;

`ifdef PC_FLOW_OVFL_EN
    logic v_reg, v_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) v_reg <= 1'b0;
        else     v_reg <= v_next;
    end

    always_comb begin
        v_next = v_reg;
        if (advance && bus.we_v) v_next = bus.ov;
    end

    assign v_flag = v_reg;
`else
    logic unused_ovfl;
    assign v_flag      = 1'b0;
    assign unused_ovfl = &{1'b0, bus.ov, bus.we_v};
`endif

    // Only the sign bit of the ALU result feeds the N flag.
    logic unused_dst;
    assign unused_dst = &{1'b0, bus.dst[14:0]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
            z_reg     <= 1'b0;
            n_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            z_reg     <= z_next;
            n_reg     <= n_next;
        end
    end

    // Next-state logic: halt beats every transfer, jr > jal > conditional branch.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        z_next     = z_reg;
        n_next     = n_reg;
        if (advance) begin
            if (bus.we_z) z_next = bus.zr;
            if (bus.we_n) n_next = bus.dst[15];
            if (bus.hlt) begin
                state_next = HALT;
            end else if (bus.jr) begin
                pc_next = bus.jr_tgt;
            end else if (bus.jal) begin
                pc_next = pc_inc + {{4{bus.jmp_off[11]}}, bus.jmp_off};
            end else if (bus.br && cond_true) begin
                pc_next = pc_inc + {{7{bus.br_off[8]}}, bus.br_off};
            end else begin
                pc_next = pc_inc;
            end
        end
    end

    // Output logic: conditions see only the registered flags, never this cycle's writes.
    always_comb begin
        cond_true = 1'b0;
        case (bus.cond)
            3'b000:  cond_true = !z_reg;
            3'b001:  cond_true = z_reg;
            3'b010:  cond_true = !z_reg && !n_reg;
            3'b011:  cond_true = n_reg;
            3'b100:  cond_true = z_reg || !n_reg;
            3'b101:  cond_true = z_reg || n_reg;
            3'b110:  cond_true = v_flag;
            default: cond_true = 1'b1;
        endcase
        bus.taken = run && !bus.hlt && (bus.jr || bus.jal || (bus.br && cond_true));
    end

    assign bus.pc       = pc_reg;
    assign bus.pc_plus1 = pc_inc;
    assign bus.halted   = (state_reg == HALT);
    assign bus.flags    = {z_reg, v_flag, n_reg};
endmodule
